// File: rtl/mem_burst_ctrl_pkg.sv
// Shared FSM encodings, beat geometry and grant identifiers for the burst controller.
// Constants only; no latency or flow-control behaviour of its own.
package mem_burst_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_BEAT = 3'd1;
    localparam logic [2:0] ST_WR_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_RESP = 3'd3;
    localparam logic [2:0] ST_RD_ADDR = 3'd4;
    localparam logic [2:0] ST_RD_DATA = 3'd5;

    localparam int BEAT_BYTES = 4;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/mem_burst_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, combinational grant qualified by en, registered last grant.
// Zero-cycle grant; a tie goes to the channel opposite the last winner (write after reset).
module rr_arb2
    import mem_burst_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_wr_o = 1'b0;
        gnt_rd_o = 1'b0;
        last_d   = last_q;
        if (en_i) begin
            if (req_wr_i && (!req_rd_i || last_q == GRANT_RD)) begin
                gnt_wr_o = 1'b1;
                last_d   = GRANT_WR;
            end else if (req_rd_i) begin
                gnt_rd_o = 1'b1;
                last_d   = GRANT_RD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= GRANT_RD;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer between write/read burst channels and a negedge-sampled 128x8 byte memory.
// Writes take 2 cycles/beat; read beats are held until rd_data_ready; only IDLE accepts requests.
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [LEN_W-1:0]  wr_req_len,
    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_resp_valid,
    input  logic              wr_resp_ready,
    output logic              wr_resp_err,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic              rd_data_valid,
    input  logic              rd_data_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_last,
    output logic              rd_data_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_writefinish
);

    // Highest start address whose whole 4-byte word fits in memory.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((1 << ADDR_W) - BEAT_BYTES);
    localparam logic [LEN_W:0]    ONE_BEAT  = (LEN_W+1)'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W:0]    beats_q, beats_d;
    logic              err_q, err_d;
    logic              wr_req_ready_q, wr_req_ready_d, rd_req_ready_q, rd_req_ready_d;
    logic              wr_data_ready_q, wr_data_ready_d;
    logic              wr_resp_valid_q, wr_resp_valid_d, wr_resp_err_q, wr_resp_err_d;
    logic              rd_data_valid_q, rd_data_valid_d, rd_data_last_q, rd_data_last_d;
    logic              rd_data_err_q, rd_data_err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, mem_wdata_q, mem_wdata_d;
    logic              mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d, mem_raddr_q, mem_raddr_d;
    logic              gnt_wr, gnt_rd;
    logic [ADDR_W-1:0] addr_nxt;
    logic              last_beat;

    rr_arb2 u_arb (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (state_q == ST_IDLE),
        .req_wr_i (wr_req_valid),
        .req_rd_i (rd_req_valid),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    assign addr_nxt  = cur_addr_q + ADDR_W'(BEAT_BYTES);
    assign last_beat = (beats_q == ONE_BEAT);

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        beats_d         = beats_q;
        err_d           = err_q;
        wr_req_ready_d  = 1'b0;
        rd_req_ready_d  = 1'b0;
        wr_data_ready_d = wr_data_ready_q;
        wr_resp_valid_d = wr_resp_valid_q;
        wr_resp_err_d   = wr_resp_err_q;
        rd_data_valid_d = rd_data_valid_q;
        rd_data_last_d  = rd_data_last_q;
        rd_data_err_d   = rd_data_err_q;
        rd_data_d       = rd_data_q;
        mem_cs_d        = mem_cs_q;
        mem_we_d        = mem_we_q;
        mem_waddr_d     = mem_waddr_q;
        mem_raddr_d     = mem_raddr_q;
        mem_wdata_d     = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_wr) begin
                    state_d         = ST_WR_BEAT;
                    wr_req_ready_d  = 1'b1;
                    wr_data_ready_d = 1'b1;
                    cur_addr_d      = wr_req_addr;
                    beats_d         = {1'b0, wr_req_len} + ONE_BEAT;
                end else if (gnt_rd) begin
                    state_d        = ST_RD_ADDR;
                    rd_req_ready_d = 1'b1;
                    cur_addr_d     = rd_req_addr;
                    beats_d        = {1'b0, rd_req_len} + ONE_BEAT;
                    mem_cs_d       = 1'b1;
                    mem_raddr_d    = rd_req_addr;
                end
            end
            ST_WR_BEAT: begin
                if (wr_data_valid && wr_data_ready_q) begin
                    state_d         = ST_WR_WAIT;
                    wr_data_ready_d = 1'b0;
                    if (cur_addr_q <= LAST_ADDR) begin
                        mem_cs_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_waddr_d = cur_addr_q;
                        mem_wdata_d = wr_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WR_WAIT: begin
                // The memory commits on the negedge inside this cycle; writefinish is judged at exit.
                mem_cs_d   = 1'b0;
                mem_we_d   = 1'b0;
                if (mem_we_q && !mem_writefinish) err_d = 1'b1;
                cur_addr_d = addr_nxt;
                beats_d    = beats_q - ONE_BEAT;
                if (last_beat) begin
                    state_d         = ST_WR_RESP;
                    wr_resp_valid_d = 1'b1;
                    wr_resp_err_d   = err_d;
                end else begin
                    state_d         = ST_WR_BEAT;
                    wr_data_ready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (wr_resp_ready) begin
                    state_d         = ST_IDLE;
                    wr_resp_valid_d = 1'b0;
                    wr_resp_err_d   = 1'b0;
                    err_d           = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                state_d         = ST_RD_DATA;
                mem_cs_d        = 1'b0;
                rd_data_valid_d = 1'b1;
                rd_data_last_d  = last_beat;
                if (cur_addr_q <= LAST_ADDR) begin
                    rd_data_d     = mem_rdata;
                    rd_data_err_d = 1'b0;
                end else begin
                    rd_data_d     = '0;
                    rd_data_err_d = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (rd_data_ready) begin
                    rd_data_valid_d = 1'b0;
                    rd_data_last_d  = 1'b0;
                    rd_data_err_d   = 1'b0;
                    cur_addr_d      = addr_nxt;
                    beats_d         = beats_q - ONE_BEAT;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_RD_ADDR;
                        mem_cs_d    = 1'b1;
                        mem_raddr_d = addr_nxt;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            cur_addr_q      <= '0;
            beats_q         <= '0;
            err_q           <= 1'b0;
            wr_req_ready_q  <= 1'b0;
            rd_req_ready_q  <= 1'b0;
            wr_data_ready_q <= 1'b0;
            wr_resp_valid_q <= 1'b0;
            wr_resp_err_q   <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_last_q  <= 1'b0;
            rd_data_err_q   <= 1'b0;
            rd_data_q       <= '0;
            mem_cs_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_waddr_q     <= '0;
            mem_raddr_q     <= '0;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            beats_q         <= beats_d;
            err_q           <= err_d;
            wr_req_ready_q  <= wr_req_ready_d;
            rd_req_ready_q  <= rd_req_ready_d;
            wr_data_ready_q <= wr_data_ready_d;
            wr_resp_valid_q <= wr_resp_valid_d;
            wr_resp_err_q   <= wr_resp_err_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_last_q  <= rd_data_last_d;
            rd_data_err_q   <= rd_data_err_d;
            rd_data_q       <= rd_data_d;
            mem_cs_q        <= mem_cs_d;
            mem_we_q        <= mem_we_d;
            mem_waddr_q     <= mem_waddr_d;
            mem_raddr_q     <= mem_raddr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign wr_req_ready  = wr_req_ready_q;
    assign rd_req_ready  = rd_req_ready_q;
    assign wr_data_ready = wr_data_ready_q;
    assign wr_resp_valid = wr_resp_valid_q;
    assign wr_resp_err   = wr_resp_err_q;
    assign rd_data_valid = rd_data_valid_q;
    assign rd_data_last  = rd_data_last_q;
    assign rd_data_err   = rd_data_err_q;
    assign rd_data       = rd_data_q;
    assign mem_cs        = mem_cs_q;
    assign mem_we        = mem_we_q;
    assign mem_waddr     = mem_waddr_q;
    assign mem_raddr     = mem_raddr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule
